conv_mac_pipe_acc: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit for the CNN convolution kernels. It replaces the fixed 16x8 combinational multiplier with a configurable-width multiplier (MUL_STAGES register stages) and an accumulator that sums ACC_LEN products per output window. Each result is rounded, shifted and saturated to DOUT_WIDTH. Valid/ready handshakes on both sides let it sit directly between the line-buffer/weight-fetch stage and the activation/writeback stage of a conv layer.

---
 rtl/conv_mac_pipe_acc.sv | 113 +++++++++++
 tb/tb_conv_mac_pipe_acc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_pipe_acc.sv
// Pipelined signed MAC for conv kernels: operand register, MUL_STAGES product
// registers, windowed accumulator, then round/shift/saturate into a skid-free output register.
module conv_mac_pipe_acc #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 16,
    parameter int MUL_STAGES = 2,
    parameter int ACC_LEN    = 9,
    parameter int SHIFT      = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_sat
);
    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
    localparam int CW  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] RND  = (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RSH) : (ACC_WIDTH+1)'(0);
    localparam logic signed [ACC_WIDTH:0] MAXV = ((ACC_WIDTH+1)'(1) << (DOUT_WIDTH-1)) - (ACC_WIDTH+1)'(1);
    localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

    logic                         en, acc_fire, win_end;
    logic signed [DIN0_WIDTH-1:0] a_q;
    logic signed [DIN1_WIDTH-1:0] b_q;
    logic [MUL_STAGES:0]          vld_pipe;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         prod_pipe [1:MUL_STAGES];
    logic signed [ACC_WIDTH-1:0]  acc, prod_ext, sum;
    logic [CW-1:0]                tap_cnt;
    logic signed [ACC_WIDTH:0]    sum_x, rnd_x;
    logic signed [DOUT_WIDTH-1:0] dout_nx;
    logic                         sat_nx;

    // A full output register that is not being drained freezes everything upstream.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign prod     = PW'(a_q) * PW'(b_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            vld_pipe <= '0;
            for (int i = 1; i <= MUL_STAGES; i++) prod_pipe[i] <= '0;
        end else if (en) begin
            a_q          <= din0;
            b_q          <= din1;
            vld_pipe[0]  <= in_valid;
            prod_pipe[1] <= prod;
            for (int i = 1; i <= MUL_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            for (int i = 2; i <= MUL_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    assign prod_ext = ACC_WIDTH'(prod_pipe[MUL_STAGES]);
    assign sum      = (tap_cnt == '0) ? prod_ext : acc + prod_ext;
    assign acc_fire = en && vld_pipe[MUL_STAGES];
    assign win_end  = (tap_cnt == CW'(ACC_LEN-1));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc     <= '0;
            tap_cnt <= '0;
        end else if (acc_fire) begin
            if (win_end) begin
                tap_cnt <= '0;
            end else begin
                acc     <= sum;
                tap_cnt <= tap_cnt + CW'(1);
            end
        end
    end

    // One extra bit keeps the rounding add from wrapping before the shift.
    assign sum_x = (ACC_WIDTH+1)'(sum) + RND;
    assign rnd_x = sum_x >>> SHIFT;

    always_comb begin
        dout_nx = rnd_x[DOUT_WIDTH-1:0];
        sat_nx  = 1'b0;
        if (rnd_x > MAXV) begin
            dout_nx = DOUT_WIDTH'(MAXV);
            sat_nx  = 1'b1;
        end else if (rnd_x < MINV) begin
            dout_nx = DOUT_WIDTH'(MINV);
            sat_nx  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            dout_sat  <= 1'b0;
        end else if (en) begin
            if (acc_fire && win_end) begin
                out_valid <= 1'b1;
                dout      <= dout_nx;
                dout_sat  <= sat_nx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_mac_pipe_acc.sv
// Scoreboard bench for conv_mac_pipe_acc: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_conv_mac_pipe_acc;
    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] din0;
    logic signed [7:0]  din1;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] dout;
    logic               dout_sat;

    typedef struct {
        logic signed [15:0] d;
        logic               s;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   pushes = 0;
    int   outs   = 0;
    bit   stall_arm = 1'b0;

    conv_mac_pipe_acc dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .dout_sat (dout_sat)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Monitor: sample mid-cycle, after all stimulus processes have settled.
    always @(negedge ap_clk) begin
        exp_t e;
        #2;
        if (ap_rst_n && out_valid && out_ready) begin
            outs++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out dout=%0d sat=%0b with empty scoreboard", dout, dout_sat);
            end else begin
                e = sbq.pop_front();
                if (dout !== e.d || dout_sat !== e.s) begin
                    errors++;
                    $display("FAIL out[%0d] dout=%0d sat=%0b expected dout=%0d sat=%0b",
                             outs, dout, dout_sat, e.d, e.s);
                end
            end
        end
    end

    // Backpressure: once armed, stall the first result for 6 cycles.
    initial begin
        int n;
        out_ready = 1'b1;
        wait (stall_arm);
        n = 0;
        do begin
            @(negedge ap_clk);
            n++;
        end while (!out_valid && n < 1000);
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL stall_wait out_valid=%0b required 1 within 1000 cycles", out_valid);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d] in_ready=%0b out_valid=%0b required 0 and 1", k, in_ready, out_valid);
            end
            @(negedge ap_clk);
        end
        out_ready = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int d, input bit s);
        exp_t e;
        e.d = 16'(d);
        e.s = s;
        sbq.push_back(e);
        pushes++;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int a, input int b);
        int n;
        din0 = 16'(a);
        din1 = 8'(b);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge ap_clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b required 1 within 200 cycles", in_ready);
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge ap_clk);
    endtask

    // Last pair was accepted at the preceding posedge: result visible 3 edges later, for 1 cycle.
    task automatic lat_check(input string name);
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge ap_clk);
            chk($sformatf("%s_lat+%0d", name, k), 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge ap_clk);
            n++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge ap_clk);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_sat", 32'(dout_sat), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // 1: basic window and latency
        push(9, 1'b0);
        for (int i = 0; i < 9; i++) send(256, 1);
        lat_check("basic");
        drain();

        // 2: rounding half toward +inf
        push(0, 1'b0);
        push(-1, 1'b0);
        for (int i = 0; i < 8; i++) send(0, 0);
        send(-128, 1);
        for (int i = 0; i < 8; i++) send(0, 0);
        send(-129, 1);
        drain();

        // 3: saturation both rails
        push(32767, 1'b1);
        push(-32768, 1'b1);
        for (int i = 0; i < 9; i++) send(32767, 127);
        for (int i = 0; i < 9; i++) send(-32768, 127);
        drain();

        // 4: backpressure across three windows
        stall_arm = 1'b1;
        for (int k = 1; k <= 3; k++) push(9 * k, 1'b0);
        for (int k = 1; k <= 3; k++)
            for (int i = 0; i < 9; i++) send(256, k);
        drain();

        // 5: reset mid-window discards the partial sum
        for (int i = 0; i < 4; i++) send(1000, 100);
        in_valid = 1'b0;
        #3 ap_rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        push(9, 1'b0);
        for (int i = 0; i < 9; i++) send(256, 1);
        drain();

        // 6: bubbles between every pair
        push(18, 1'b0);
        for (int i = 0; i < 9; i++) begin
            send(256, 2);
            if (i < 8) idle(1);
        end
        lat_check("bubble");
        drain();

        chk("total_outputs", 32'(outs), 32'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
